blink_scheduler: RTL and testbench

BLINK_SCHEDULER -- requirements
Module: blink_scheduler

---
 rtl/blink_pkg.sv | 17 +
 rtl/blink_rr_arbiter.sv | 47 ++++
 rtl/blink_scheduler.sv | 116 +++++++++++
 tb/tb_blink_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared state encoding and blink-type constants for the LED blink scheduler and its blinker.
package blink_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_LAUNCH = 2'd1;
   localparam state_t ST_BUSY   = 2'd2;
   localparam state_t ST_GAP    = 2'd3;

   localparam logic BLINK_TYPE_ERROR   = 1'b0;
   localparam logic BLINK_TYPE_SUCCESS = 1'b1;

   // Cycles start_blinking is held before done_blinking is trusted (blinker edge-detect latency).
   localparam logic [31:0] LAUNCH_CYCLES = 32'd2;

endpackage

// File: rtl/blink_rr_arbiter.sv
// Pending-request flags with coalescing and round-robin choice between error and success sequences.
module blink_rr_arbiter
   import blink_pkg::*;
(
   input  logic hwclk,
   input  logic rst_n,
   input  logic req_error,
   input  logic req_success,
   input  logic take,
   output logic pending,
   output logic pick
);

   logic pend_err;
   logic pend_suc;
   logic last_err;
   logic grant_err;
   logic grant_suc;

   // last_err=0 means success was served last, so error wins the first tie after reset.
   always_comb begin
      pick = BLINK_TYPE_ERROR;
      if (pend_err && pend_suc)
         pick = last_err ? BLINK_TYPE_SUCCESS : BLINK_TYPE_ERROR;
      else if (pend_suc)
         pick = BLINK_TYPE_SUCCESS;
   end

   assign pending   = pend_err | pend_suc;
   assign grant_err = take && (pick == BLINK_TYPE_ERROR);
   assign grant_suc = take && (pick == BLINK_TYPE_SUCCESS);

   // A request landing on its own grant keeps the flag set so it is served again.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         pend_err <= 1'b0;
         pend_suc <= 1'b0;
         last_err <= 1'b0;
      end else begin
         pend_err <= req_error   | (pend_err & ~grant_err);
         pend_suc <= req_success | (pend_suc & ~grant_suc);
         if (take)
            last_err <= (pick == BLINK_TYPE_ERROR);
      end
   end

endmodule

// File: rtl/blink_scheduler.sv
// LED blink sequence scheduler: arbitrates error/success requests and paces the external blinker.
// Optional BUSY watchdog is enabled by defining BLINK_SCHED_TIMEOUT_EN.
module blink_scheduler
   import blink_pkg::*;
#(
   parameter logic [31:0] GAP_CYCLES     = 32'd1200000,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd48000000
) (
   input  logic       hwclk,
   input  logic       rst_n,
   input  logic       req_error,
   input  logic       req_success,
   output logic       start_blinking,
   output logic       blink_type,
   input  logic       done_blinking,
   output logic       busy,
   output logic [1:0] grant,
   output logic       timeout_err
);

   // Reload values for the shared down-counter; a zero-length GAP or timeout acts as one cycle.
   localparam logic [31:0] LAUNCH_LOAD  = LAUNCH_CYCLES - 32'd1;
   localparam logic [31:0] GAP_LOAD     = (GAP_CYCLES == 32'd0) ? 32'd0 : GAP_CYCLES - 32'd1;
   localparam logic [31:0] TIMEOUT_LOAD = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;

   state_t      state;
   logic [31:0] cnt;
   logic        pending;
   logic        pick;
   logic        take;

   function automatic logic [31:0] sat_dec(input logic [31:0] v);
      return (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction

   assign take = (state == ST_IDLE) && pending;
   assign busy = (state != ST_IDLE);

   blink_rr_arbiter u_arb (
      .hwclk       (hwclk),
      .rst_n       (rst_n),
      .req_error   (req_error),
      .req_success (req_success),
      .take        (take),
      .pending     (pending),
      .pick        (pick)
   );

`ifdef BLINK_SCHED_TIMEOUT_EN
   logic tmo_q;
   assign timeout_err = tmo_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         cnt            <= 32'd0;
         start_blinking <= 1'b0;
         blink_type     <= BLINK_TYPE_ERROR;
         grant          <= 2'b00;
`ifdef BLINK_SCHED_TIMEOUT_EN
         tmo_q          <= 1'b0;
`endif
      end else begin
         grant <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  state          <= ST_LAUNCH;
                  cnt            <= LAUNCH_LOAD;
                  start_blinking <= 1'b1;
                  blink_type     <= pick;
                  grant          <= (pick == BLINK_TYPE_SUCCESS) ? 2'b10 : 2'b01;
               end
            end
            // done_blinking is deliberately ignored here: the blinker has not reacted yet.
            ST_LAUNCH: begin
               if (cnt == 32'd0) begin
                  state <= ST_BUSY;
                  cnt   <= TIMEOUT_LOAD;
               end else begin
                  cnt <= sat_dec(cnt);
               end
            end
            ST_BUSY: begin
               if (done_blinking) begin
                  start_blinking <= 1'b0;
                  state          <= ST_GAP;
                  cnt            <= GAP_LOAD;
               end
`ifdef BLINK_SCHED_TIMEOUT_EN
               else if (cnt == 32'd0) begin
                  tmo_q          <= 1'b1;
                  start_blinking <= 1'b0;
                  state          <= ST_GAP;
                  cnt            <= GAP_LOAD;
               end
`endif
               else begin
                  cnt <= sat_dec(cnt);
               end
            end
            ST_GAP: begin
               if (cnt == 32'd0)
                  state <= ST_IDLE;
               else
                  cnt <= sat_dec(cnt);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blink_scheduler.sv
// Bench for blink_scheduler: randomized and directed requests against a timeline-based reference model.
module tb_blink_scheduler;
   import blink_pkg::*;

   localparam int GAP = 4;
   localparam int TMO = 20;

   logic       hwclk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_error = 1'b0;
   logic       req_success = 1'b0;
   logic       done_blinking = 1'b1;
   logic       start_blinking;
   logic       blink_type;
   logic       busy;
   logic       timeout_err;
   logic [1:0] grant;

   blink_scheduler #(.GAP_CYCLES(32'd4), .TIMEOUT_CYCLES(32'd20)) dut (
      .hwclk          (hwclk),
      .rst_n          (rst_n),
      .req_error      (req_error),
      .req_success    (req_success),
      .start_blinking (start_blinking),
      .blink_type     (blink_type),
      .done_blinking  (done_blinking),
      .busy           (busy),
      .grant          (grant),
      .timeout_err    (timeout_err)
   );

   always #5 hwclk = ~hwclk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: pending flags plus the timeline of the current sequence.
   bit   m_pend [2];
   bit   m_last   = 1'b1;
   bit   m_active = 1'b0;
   bit   m_type   = 1'b0;
   bit   m_tmo    = 1'b0;
   int   m_launch = 0;
   int   m_stop   = -1;
   logic [1:0] m_grant = 2'b00;

   logic [1:0] g_log [$];

   // Blinker model: drops done on start's rising edge, raises it after bl_left cycles.
   int bl_left  = 0;
   int bl_fixed = 0;
   bit bl_stuck = 1'b0;
   bit prev_start = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pend[0] = 1'b0;
      m_pend[1] = 1'b0;
      m_last    = 1'b1;
      m_active  = 1'b0;
      m_type    = 1'b0;
      m_tmo     = 1'b0;
      m_stop    = -1;
      m_grant   = 2'b00;
   endtask

   task automatic model_edge(input bit re, input bit rs, input bit d);
      bit typ;
      m_grant = 2'b00;
      if (m_active) begin
         if (m_stop < 0 && cyc >= m_launch + 3) begin
            if (d) m_stop = cyc;
`ifdef BLINK_SCHED_TIMEOUT_EN
            else if (cyc == m_launch + 2 + TMO) begin
               m_stop = cyc;
               m_tmo  = 1'b1;
            end
`endif
         end
         if (m_stop >= 0 && cyc == m_stop + GAP) m_active = 1'b0;
      end else if (m_pend[0] || m_pend[1]) begin
         if (m_pend[0] && m_pend[1]) typ = !m_last;
         else                        typ = m_pend[1];
         m_pend[typ] = 1'b0;
         m_last   = typ;
         m_type   = typ;
         m_active = 1'b1;
         m_launch = cyc;
         m_stop   = -1;
         m_grant  = typ ? 2'b10 : 2'b01;
      end
      if (re) m_pend[0] = 1'b1;
      if (rs) m_pend[1] = 1'b1;
   endtask

   task automatic blinker_tick();
      if (start_blinking === 1'b1 && !prev_start) begin
         done_blinking = 1'b0;
         bl_left = (bl_fixed > 0) ? bl_fixed : int'($urandom_range(12, 3));
      end else if (!done_blinking && !bl_stuck) begin
         bl_left--;
         if (bl_left <= 0) done_blinking = 1'b1;
      end
      prev_start = (start_blinking === 1'b1);
   endtask

   task automatic step(input bit re, input bit rs);
      req_error   = re;
      req_success = rs;
      @(posedge hwclk);
      cyc++;
      model_edge(re, rs, done_blinking);
      #1;
      req_error   = 1'b0;
      req_success = 1'b0;
      check_eq("start_blinking", 32'(start_blinking), 32'(m_active && m_stop < 0));
      check_eq("busy",           32'(busy),           32'(m_active));
      check_eq("grant",          32'(grant),          32'(m_grant));
      check_eq("blink_type",     32'(blink_type),     32'(m_type));
      check_eq("timeout_err",    32'(timeout_err),    32'(m_tmo));
      if (grant != 2'b00) g_log.push_back(grant);
      blinker_tick();
   endtask

   task automatic run_quiet(input int maxc);
      int n = 0;
      while ((busy || m_active || m_pend[0] || m_pend[1] || !done_blinking) && n < maxc) begin
         step(1'b0, 1'b0);
         n++;
      end
      check_eq("settle_in_budget", 32'(n < maxc), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_time_limit: observed running expected finished (cycle %0d)", cyc);
      $fatal(1, "time limit");
   end

   initial begin
      bit hit;
      int n;
      model_reset();

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_start", 32'(start_blinking), 32'd0);
      check_eq("rst_busy",  32'(busy),           32'd0);
      check_eq("rst_grant", 32'(grant),          32'd0);
      check_eq("rst_type",  32'(blink_type),     32'd0);
      check_eq("rst_tmo",   32'(timeout_err),    32'd0);
      repeat (2) begin @(posedge hwclk); cyc++; end
      #1 rst_n = 1'b1;
      bl_fixed = 10;

      // Simultaneous requests: error first, success right after GAP
      g_log.delete();
      step(1'b1, 1'b1);
      run_quiet(200);
      check_eq("tie_launches", 32'(g_log.size()), 32'd2);
      if (g_log.size() == 2) begin
         check_eq("tie_first",  32'(g_log[0]), 32'd1);
         check_eq("tie_second", 32'(g_log[1]), 32'd2);
      end

      // Single error request
      g_log.delete();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check_eq("err_grant", 32'(grant),          32'd1);
      check_eq("err_start", 32'(start_blinking), 32'd1);
      check_eq("err_type",  32'(blink_type),     32'd0);
      run_quiet(100);
      check_eq("err_launches", 32'(g_log.size()), 32'd1);

      // Three success pulses during one BUSY coalesce into one launch
      g_log.delete();
      step(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      run_quiet(200);
      check_eq("coal_launches", 32'(g_log.size()), 32'd2);
      if (g_log.size() == 2) check_eq("coal_second", 32'(g_log[1]), 32'd2);

      // Error flood with one success request
      g_log.delete();
      step(1'b1, 1'b1);
      repeat (80) step(1'b1, 1'b0);
      run_quiet(300);
      hit = (g_log.size() >= 2) && (g_log[0] == 2'b10 || g_log[1] == 2'b10);
      check_eq("flood_success_by_2nd", 32'(hit), 32'd1);

      // Randomized traffic
      bl_fixed = 0;
      repeat (3000) step($urandom_range(15, 0) == 0, $urandom_range(19, 0) == 0);
      run_quiet(500);

      // Blinker never finishes
      bl_fixed = 10;
      bl_stuck = 1'b1;
      step(1'b1, 1'b0);
`ifdef BLINK_SCHED_TIMEOUT_EN
      n = 0;
      step(1'b0, 1'b0);
      while (busy && n < 200) begin
         step(1'b0, 1'b0);
         n++;
      end
      check_eq("tmo_in_budget", 32'(n < 200), 32'd1);
      check_eq("tmo_flag",  32'(timeout_err),    32'd1);
      check_eq("tmo_start", 32'(start_blinking), 32'd0);
`else
      n = 0;
      repeat (1000) step(1'b0, 1'b0);
      check_eq("hold_busy",  32'(busy),           32'd1);
      check_eq("hold_start", 32'(start_blinking), 32'd1);
`endif
      bl_stuck = 1'b0;
      bl_left  = 1;
      run_quiet(200);

      // Reset mid-BUSY with a success request pending
      step(1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check_eq("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_start", 32'(start_blinking), 32'd0);
      check_eq("mid_rst_busy",  32'(busy),           32'd0);
      check_eq("mid_rst_tmo",   32'(timeout_err),    32'd0);
      model_reset();
      repeat (3) begin
         @(posedge hwclk);
         cyc++;
         #1;
         blinker_tick();
      end
      rst_n = 1'b1;
      g_log.delete();
      run_quiet(100);
      check_eq("post_rst_no_launch", 32'(g_log.size()), 32'd0);
      step(1'b0, 1'b1);
      run_quiet(100);
      check_eq("post_rst_launches", 32'(g_log.size()), 32'd1);
      if (g_log.size() == 1) check_eq("post_rst_grant", 32'(g_log[0]), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
